// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V memory stage: data-memory access FSM, branch resolve, write-back register
// A held access is issued once; DONE drops the stall for one cycle so the pipeline advances before IDLE can re-issue.
module memory_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int PC_W    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rf_we_i,
   input  logic              mem_we_i,
   input  logic              mem2rf_i,
   input  logic              branch_i,
   input  logic              check_eq_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [ADDR_W-1:0] rf_waddr_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [PC_W-1:0]   pc_branch_i,
   output logic              mem_req_o,
   output logic              mem_wr_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              pc_src_o,
   output logic [PC_W-1:0]   pc_branch_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic              err_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_cnt;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rbuf;
   logic              r_wr;
   logic              r_err;
   logic              w_access;
   logic              w_load;
   logic              w_timeout;
   logic              w_stall;
   logic              w_req;

   assign w_access  = mem_we_i | mem2rf_i;
   // A store wins when both flags are set, so memory data never reaches write-back.
   assign w_load    = mem2rf_i & ~mem_we_i;
   assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_access) w_next = S_REQ;
         S_REQ:   if (mem_ready_i || w_timeout) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_req   = 1'b0;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE:  w_stall = w_access;
         S_REQ:   begin w_req = 1'b1; w_stall = 1'b1; end
         default: ;
      endcase
   end

   assign mem_req_o   = w_req;
   assign stall_o     = w_stall & ~reset;
   assign mem_wr_o    = r_wr;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign err_o       = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wr    <= 1'b0;
         r_rbuf  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  r_addr  <= alu_result_i;
                  r_wdata <= mem_wdata_i;
                  r_wr    <= mem_we_i;
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               if (mem_ready_i) begin
                  r_rbuf <= mem_rdata_i;
               end else if (w_timeout) begin
                  r_err  <= 1'b1;
                  r_rbuf <= '0;
               end else begin
                  r_cnt  <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc_src_o    = branch_i & (check_eq_i ? (alu_result_i == '0) : (alu_result_i != '0));
   assign pc_branch_o = pc_branch_i;

   // Stall cycles become write-back bubbles; address and data hold their last values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
      end else if (w_stall) begin
         rf_we_o    <= 1'b0;
      end else begin
         rf_we_o    <= rf_we_i;
         rf_waddr_o <= rf_waddr_i;
         rf_wdata_o <= w_load ? r_rbuf : alu_result_i;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rf_we_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic        mem2rf_i = 1'b0;
   logic        branch_i = 1'b0;
   logic        check_eq_i = 1'b0;
   logic [31:0] mem_wdata_i = '0;
   logic [4:0]  rf_waddr_i = '0;
   logic [31:0] alu_result_i = '0;
   logic [31:0] pc_branch_i = '0;
   logic        mem_req_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        stall_o;
   logic        pc_src_o;
   logic [31:0] pc_branch_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        err_o;

   int n_cmp = 0;
   int n_err = 0;

   memory_stage dut (
      .clk(clk), .reset(reset), .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
      .branch_i(branch_i), .check_eq_i(check_eq_i), .mem_wdata_i(mem_wdata_i),
      .rf_waddr_i(rf_waddr_i), .alu_result_i(alu_result_i), .pc_branch_i(pc_branch_i),
      .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
      .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_branch_o(pc_branch_o), .rf_we_o(rf_we_o),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_nop();
      rf_we_i = 1'b0; mem_we_i = 1'b0; mem2rf_i = 1'b0; branch_i = 1'b0;
      rf_waddr_i = '0; alu_result_i = '0; mem_wdata_i = '0;
   endtask

   // Presents one access, answers with ready on REQ cycle wait_n (0 = never), returns at the DONE cycle.
   task automatic run_mem(input logic we, input logic ld, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n,
                          output int n_req, output int n_stall, output logic hold_ok);
      n_req = 0; n_stall = 0; hold_ok = 1'b1;
      @(posedge clk); #1;
      mem_we_i = we; mem2rf_i = ld; rf_we_i = ld; rf_waddr_i = 5'd7;
      alu_result_i = addr; mem_wdata_i = wdata;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (mem_req_o) begin
            n_req++;
            if (mem_addr_o !== addr || mem_wr_o !== we || (we && mem_wdata_o !== wdata)) hold_ok = 1'b0;
            mem_ready_i = (n_req == wait_n);
            mem_rdata_i = rdata;
         end else begin
            mem_ready_i = 1'b0;
         end
         if (stall_o) n_stall++;
         else break;
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      set_nop();
   endtask

   int   nr, ns;
   logic ok;

   initial begin
      pc_branch_i = 32'h0000_1000;
      repeat (2) @(negedge clk);
      check("rst_req", mem_req_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_rfwe", rf_we_o, 0);
      check("rst_wdata", rf_wdata_o, 0);
      check("rst_err", err_o, 0);
      @(posedge clk); #1; reset = 1'b0;

      // ALU op: write-back one cycle later, no stall
      rf_we_i = 1'b1; rf_waddr_i = 5'd5; alu_result_i = 32'h1234;
      @(negedge clk);
      check("alu_stall", stall_o, 0);
      @(posedge clk); #1; set_nop();
      check("alu_rfwe", rf_we_o, 1);
      check("alu_waddr", rf_waddr_o, 5);
      check("alu_wdata", rf_wdata_o, 32'h1234);
      check("alu_stall2", stall_o, 0);

      // Branch resolution
      branch_i = 1'b1; check_eq_i = 1'b1; alu_result_i = 32'd0; #1;
      check("beq_taken", pc_src_o, 1);
      check("br_target", pc_branch_o, 32'h0000_1000);
      alu_result_i = 32'd3; #1;
      check("beq_not", pc_src_o, 0);
      check_eq_i = 1'b0; #1;
      check("bne_taken", pc_src_o, 1);
      branch_i = 1'b0; #1;
      check("nobranch", pc_src_o, 0);
      set_nop();

      // Load, ready on third REQ cycle
      run_mem(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF, 3, nr, ns, ok);
      check("ld_nreq", nr, 3);
      check("ld_nstall", ns, 4);
      check("ld_hold", ok, 1);
      @(negedge clk);
      check("ld_rfwe", rf_we_o, 1);
      check("ld_waddr", rf_waddr_o, 7);
      check("ld_wdata", rf_wdata_o, 32'hDEAD_BEEF);
      @(negedge clk);
      check("ld_rfwe_once", rf_we_o, 0);
      check("ld_noreissue", mem_req_o, 0);

      // Store, immediate ready, no write-back
      run_mem(1'b1, 1'b0, 32'h80, 32'hCAFE, 32'h0, 1, nr, ns, ok);
      check("st_nreq", nr, 1);
      check("st_nstall", ns, 2);
      check("st_hold", ok, 1);
      check("st_wr", mem_wr_o, 1);
      check("st_wdata", mem_wdata_o, 32'hCAFE);
      @(negedge clk);
      check("st_rfwe", rf_we_o, 0);
      check("st_err", err_o, 0);

      // Timeout: ready never arrives
      run_mem(1'b0, 1'b1, 32'h44, 32'h0, 32'h5555_AAAA, 0, nr, ns, ok);
      check("to_nreq", nr, 255);
      check("to_nstall", ns, 256);
      check("to_err", err_o, 1);
      @(negedge clk);
      check("to_rfwe", rf_we_o, 1);
      check("to_wdata", rf_wdata_o, 0);
      rf_we_i = 1'b1; rf_waddr_i = 5'd3; alu_result_i = 32'h99;
      @(posedge clk); #1; set_nop();
      check("to_resume", rf_wdata_o, 32'h99);
      check("to_sticky", err_o, 1);

      // Reset in the middle of REQ
      @(posedge clk); #1;
      mem2rf_i = 1'b1; rf_we_i = 1'b1; rf_waddr_i = 5'd9; alu_result_i = 32'h60;
      repeat (3) @(negedge clk);
      check("mid_req", mem_req_o, 1);
      #1 reset = 1'b1;
      #1;
      check("arst_req", mem_req_o, 0);
      check("arst_stall", stall_o, 0);
      check("arst_rfwe", rf_we_o, 0);
      check("arst_err", err_o, 0);
      check("arst_addr", mem_addr_o, 0);
      @(posedge clk); #1; set_nop(); reset = 1'b0;
      run_mem(1'b1, 1'b0, 32'h84, 32'h1357, 32'h0, 2, nr, ns, ok);
      check("post_nreq", nr, 2);
      check("post_nstall", ns, 3);
      check("post_hold", ok, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
